// File: rtl/mod_arbiter.sv
// -----------------------------------------------------------------------------
// mod_arbiter
//
// Shares one modular-reduction engine between N requesters. A round-robin
// arbiter picks an owner, the owner's operands are loaded into the engine, and
// the block waits for the engine result (or a timeout). The owner then gets a
// one-cycle oDone or oErr pulse. The engine enable drops between jobs, so every
// job starts from a freshly cleared engine.
//
// Ports
//   iClk, iReset_n   clock, asynchronous active-low reset
//   iReq[N]          per-requester job request (level)
//   iX, iY[N*iW]     flattened dividends / moduli, slice k = requester k
//   oGrant[N]        one-hot engine owner, held from LOAD through DONE/ERR
//   oDone, oErr[N]   one-cycle completion / timeout pulse to the owner
//   oZ[oW]           result of the last completed job
//   oBusy            high whenever a job is in progress
//   oModEnable       engine enable (low clears the engine)
//   oModLoad         engine load strobe
//   oModX, oModY     operands of the current owner, zero when nobody owns
//   iModValid, iModZ engine result-valid pulse and result
// -----------------------------------------------------------------------------
module mod_arbiter #(
    parameter int N       = 4,
    parameter int iW      = 2048,
    parameter int oW      = 1024,
    parameter int TIMEOUT = 1000000
) (
    input  logic            iClk,
    input  logic            iReset_n,
    input  logic [N-1:0]    iReq,
    input  logic [N*iW-1:0] iX,
    input  logic [N*iW-1:0] iY,
    output logic [N-1:0]    oGrant,
    output logic [N-1:0]    oDone,
    output logic [N-1:0]    oErr,
    output logic [oW-1:0]   oZ,
    output logic            oBusy,
    output logic            oModEnable,
    output logic            oModLoad,
    output logic [iW-1:0]   oModX,
    output logic [iW-1:0]   oModY,
    input  logic            iModValid,
    input  logic [oW-1:0]   iModZ
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = 24;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] gidx_q,  gidx_d;   // current owner
    logic [IDX_W-1:0] last_q,  last_d;   // owner of the last finished job
    logic [CNT_W-1:0] cnt_q,   cnt_d;    // WAIT cycles spent on this job
    logic [oW-1:0]    z_q,     z_d;

    // Round-robin pick: the lowest requesting index above last_q wins; if
    // there is none, wrap around to the lowest requesting index overall.
    logic [IDX_W-1:0] pick, hi_idx, lo_idx;
    logic             hi_vld;

    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        // Descending scan: the last hit written is the lowest index.
        for (int k = N - 1; k >= 0; k--) begin
            if (iReq[k]) begin
                if (IDX_W'(k) > last_q) begin
                    hi_vld = 1'b1;
                    hi_idx = IDX_W'(k);
                end else begin
                    lo_idx = IDX_W'(k);
                end
            end
        end
        pick = hi_vld ? hi_idx : lo_idx;
    end

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        unique case (state_q)
            S_IDLE: begin
                if (|iReq) begin
                    state_d = S_LOAD;
                    gidx_d  = pick;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // A result arriving on the last allowed cycle still counts.
                if (iModValid) begin
                    z_d     = iModZ;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                last_d  = gidx_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q <= S_IDLE;
            gidx_q  <= '0;
            last_q  <= IDX_LAST;
            cnt_q   <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
        end
    end

    assign oBusy      = (state_q != S_IDLE);
    assign oModEnable = (state_q == S_LOAD) || (state_q == S_WAIT);
    assign oModLoad   = (state_q == S_LOAD);
    assign oDone      = (state_q == S_DONE) ? oGrant : '0;
    assign oErr       = (state_q == S_ERR)  ? oGrant : '0;
    assign oZ         = z_q;

    // gidx_q keeps its old value in IDLE, so the grant and the operand
    // mux are qualified by oBusy.
    always_comb begin
        oGrant = '0;
        oModX  = '0;
        oModY  = '0;
        for (int k = 0; k < N; k++) begin
            if (oBusy && (gidx_q == IDX_W'(k))) begin
                oGrant[k] = 1'b1;
                oModX     = iX[k*iW +: iW];
                oModY     = iY[k*iW +: iW];
            end
        end
    end

endmodule

// File: tb/tb_mod_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mod_arbiter
//
// Two arbiters share all requester-side stimulus: instance A with TIMEOUT=64
// (long engine latencies complete) and instance B with TIMEOUT=16 (timeouts).
// Each instance has its own engine model and its own job-level reference model
// that predicts every output on every cycle. Directed scenarios add literal
// expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mod_arbiter;

    localparam int N  = 4;
    localparam int IW = 16;
    localparam int OW = 8;

    logic            iClk     = 1'b0;
    logic            iReset_n = 1'b0;
    logic [N-1:0]    req      = '0;
    logic [N*IW-1:0] x_flat   = '0;
    logic [N*IW-1:0] y_flat   = '0;

    logic [N-1:0]  grant [2];
    logic [N-1:0]  done  [2];
    logic [N-1:0]  err   [2];
    logic [OW-1:0] z     [2];
    logic          busy  [2];
    logic          en    [2];
    logic          ld    [2];
    logic [IW-1:0] mx    [2];
    logic [IW-1:0] my    [2];
    logic          mod_valid [2];
    logic [OW-1:0] mod_z     [2];

    // Engine control: latency >0 fixed, 0 random 1..20, -1 never answers.
    int            eng_lat [2];
    bit            stray   [2];
    logic [OW-1:0] stray_z;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations of the DUTs, used by the directed scenarios.
    int           n_load [2], n_done [2], n_err [2];
    int           order  [2][32];
    int           n_order[2];
    int           gap_cur[2], gap_min[2];
    int           wait_run[2], first_wait[2];
    logic [N-1:0] first_mask[2], done_mask[2], err_mask[2], grant_or[2];

    always #5 iClk = ~iClk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] pack(input logic [N-1:0] g, input logic [N-1:0] dn,
                                         input logic [N-1:0] er, input logic b, input logic e,
                                         input logic l, input logic [OW-1:0] zz,
                                         input logic [IW-1:0] xx, input logic [IW-1:0] yy);
        return {9'b0, g, dn, er, b, e, l, zz, xx, yy};
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic clear_rec();
        for (int d = 0; d < 2; d++) begin
            n_load[d] = 0; n_done[d] = 0; n_err[d] = 0; n_order[d] = 0;
            gap_cur[d] = 0; gap_min[d] = 999; wait_run[d] = 0; first_wait[d] = -1;
            first_mask[d] = '0; done_mask[d] = '0; err_mask[d] = '0; grant_or[d] = '0;
            for (int i = 0; i < 32; i++) order[d][i] = -1;
        end
    endtask

    task automatic tick();
        @(negedge iClk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c = 0;
        while ((busy[0] || busy[1]) && c < budget) begin
            tick();
            c++;
        end
        check(name, 64'(busy[0] | busy[1]), 64'd0);
    endtask

    for (genvar d = 0; d < 2; d++) begin : g_inst
        localparam int TO = (d == 0) ? 64 : 16;

        mod_arbiter #(.N(N), .iW(IW), .oW(OW), .TIMEOUT(TO)) dut (
            .iClk      (iClk),
            .iReset_n  (iReset_n),
            .iReq      (req),
            .iX        (x_flat),
            .iY        (y_flat),
            .oGrant    (grant[d]),
            .oDone     (done[d]),
            .oErr      (err[d]),
            .oZ        (z[d]),
            .oBusy     (busy[d]),
            .oModEnable(en[d]),
            .oModLoad  (ld[d]),
            .oModX     (mx[d]),
            .oModY     (my[d]),
            .iModValid (mod_valid[d]),
            .iModZ     (mod_z[d])
        );

        // Engine: answers x mod y a set number of cycles after the load
        // strobe; forgets everything when its enable drops.
        initial begin
            int            cnt;
            logic [OW-1:0] res;
            cnt = -1;
            res = '0;
            mod_valid[d] = 1'b0;
            mod_z[d]     = '0;
            forever begin
                @(negedge iClk);
                if (!iReset_n) cnt = -1;
                else if (ld[d]) begin
                    cnt = (eng_lat[d] == 0) ? int'($urandom_range(1, 20)) : eng_lat[d];
                    res = (my[d] == 0) ? '0 : OW'(mx[d] % my[d]);
                end else if (!en[d]) cnt = -1;
                @(posedge iClk);
                #1;
                mod_valid[d] = 1'b0;
                if (stray[d]) begin
                    mod_valid[d] = 1'b1;
                    mod_z[d]     = stray_z;
                    stray[d]     = 1'b0;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        mod_valid[d] = 1'b1;
                        mod_z[d]     = res;
                        cnt          = -1;
                    end
                end
            end
        end

        // Job-level reference model plus the per-cycle comparison.
        // owner: -1 when nobody holds the engine. fresh: the job's first
        // cycle (operands loaded). waited: WAIT cycles so far. outcome:
        // 0 running, 1 completed, 2 timed out (the cycle of the pulse).
        initial begin
            int            owner, last, waited, outcome, cand;
            bit            fresh;
            logic [OW-1:0] mz;
            logic [N-1:0]  eg, edn, eer;
            logic [IW-1:0] ex, ey;
            owner = -1; last = N - 1; waited = 0; outcome = 0; fresh = 0; mz = '0;
            forever begin
                @(negedge iClk);
                if (!iReset_n) begin
                    owner = -1; last = N - 1; waited = 0; outcome = 0; fresh = 0; mz = '0;
                end
                eg = '0; ex = '0; ey = '0;
                if (owner >= 0) begin
                    eg = N'(1) << owner;
                    ex = x_flat[owner*IW +: IW];
                    ey = y_flat[owner*IW +: IW];
                end
                edn = (outcome == 1) ? eg : '0;
                eer = (outcome == 2) ? eg : '0;
                check((d == 0) ? "cycle_A" : "cycle_B",
                      pack(grant[d], done[d], err[d], busy[d], en[d], ld[d], z[d], mx[d], my[d]),
                      pack(eg, edn, eer, owner >= 0, owner >= 0 && outcome == 0,
                           owner >= 0 && fresh, mz, ex, ey));

                if (iReset_n) begin
                    grant_or[d] |= grant[d];
                    if (ld[d]) begin
                        if (n_load[d] > 0 && gap_cur[d] < gap_min[d]) gap_min[d] = gap_cur[d];
                        if (n_order[d] < 32) begin
                            order[d][n_order[d]] = onehot_idx(grant[d]);
                            n_order[d]++;
                        end
                        n_load[d]++;
                        wait_run[d] = 0;
                    end else if (en[d]) wait_run[d]++;
                    if (en[d]) gap_cur[d] = 0; else gap_cur[d]++;
                    if ((|done[d] || |err[d]) && first_wait[d] < 0) begin
                        first_wait[d] = wait_run[d];
                        first_mask[d] = done[d] | err[d];
                    end
                    if (|done[d]) n_done[d]++;
                    if (|err[d])  n_err[d]++;
                    done_mask[d] |= done[d];
                    err_mask[d]  |= err[d];
                end

                @(posedge iClk);
                if (iReset_n) begin
                    if (owner < 0) begin
                        if (|req) begin
                            for (int k = 1; k <= N; k++) begin
                                cand = (last + k) % N;
                                if (req[cand]) begin
                                    owner = cand;
                                    break;
                                end
                            end
                            fresh = 1; waited = 0; outcome = 0;
                        end
                    end else if (outcome != 0) begin
                        last  = owner;
                        owner = -1;
                    end else if (fresh) begin
                        fresh = 0;
                    end else begin
                        waited++;
                        if (mod_valid[d]) begin
                            mz      = mod_z[d];
                            outcome = 1;
                        end else if (waited == TO) outcome = 2;
                    end
                end
            end
        end
    end

    initial begin
        int            c;
        logic [OW-1:0] z_keep [2];
        int            loads_keep;
        eng_lat[0] = 40; eng_lat[1] = 40;
        stray[0] = 0; stray[1] = 0;
        stray_z = '0;
        clear_rec();

        // Reset state.
        tick(); tick();
        for (int d = 0; d < 2; d++)
            check("reset_state",
                  pack(grant[d], done[d], err[d], busy[d], en[d], ld[d], z[d], mx[d], my[d]), 64'd0);
        iReset_n = 1'b1;
        tick();

        // Single job: 1000 mod 7 = 6 after 40 engine cycles (B times out).
        x_flat[0*IW +: IW] = 16'd1000;
        y_flat[0*IW +: IW] = 16'd7;
        req = 4'b0001;
        tick();
        req = '0;
        c = 0;
        while (n_done[0] == 0 && c < 100) begin tick(); c++; end
        check("s1_done_seen", 64'(n_done[0]), 64'd1);
        tick();
        check("s1_busy_after_done", 64'(busy[0]), 64'd0);
        wait_idle(50, "s1_idle");
        check("s1_z", 64'(z[0]), 64'd6);
        check("s1_loads", 64'(n_load[0]), 64'd1);
        check("s1_done_mask", 64'(done_mask[0]), 64'b0001);
        check("s1_done_count", 64'(n_done[0]), 64'd1);
        check("s1_grant", 64'(grant_or[0]), 64'b0001);
        check("s1_wait_len", 64'(first_wait[0]), 64'd40);
        check("s1_B_err", 64'(err_mask[1]), 64'b0001);
        check("s1_B_z_kept", 64'(z[1]), 64'd0);

        // Contention from a fresh reset: 0,1,2,3,0.
        // Results: 100%9=1, 137%10=7, 174%11=9, 211%12=7.
        iReset_n = 1'b0;
        tick();
        iReset_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            x_flat[k*IW +: IW] = IW'(100 + 37 * k);
            y_flat[k*IW +: IW] = IW'(9 + k);
        end
        eng_lat[0] = 5; eng_lat[1] = 5;
        clear_rec();
        req = 4'b1111;
        c = 0;
        while (n_load[0] < 5 && c < 200) begin tick(); c++; end
        req = '0;
        wait_idle(50, "s2_idle");
        check("s2_order_A", {order[0][0][3:0], order[0][1][3:0], order[0][2][3:0],
                             order[0][3][3:0], order[0][4][3:0]}, 64'h01230);
        check("s2_order_B", {order[1][0][3:0], order[1][1][3:0], order[1][2][3:0],
                             order[1][3][3:0], order[1][4][3:0]}, 64'h01230);
        check("s2_gap", 64'(gap_min[0] >= 1 && gap_min[1] >= 1), 64'd1);
        check("s2_z", 64'(z[0]), 64'd1);

        // Timeout on B: requesters 1 and 0 both time out after 16 WAIT cycles.
        eng_lat[0] = -1; eng_lat[1] = -1;
        clear_rec();
        req = 4'b0011;
        c = 0;
        while (n_load[1] < 2 && c < 100) begin tick(); c++; end
        req = '0;
        wait_idle(200, "s3_idle");
        check("s3_order_B", {order[1][0][3:0], order[1][1][3:0]}, 64'h10);
        check("s3_wait_len", 64'(first_wait[1]), 64'd16);
        check("s3_err_owner", 64'(first_mask[1]), 64'b0010);
        check("s3_err_mask", 64'(err_mask[1]), 64'b0011);
        check("s3_no_done", 64'(n_done[1]), 64'd0);
        check("s3_z_kept", 64'(z[1]), 64'd1);

        // Valid on the last allowed WAIT cycle of B: 174 mod 11 = 9.
        eng_lat[0] = 16; eng_lat[1] = 16;
        clear_rec();
        req = 4'b0100;
        tick();
        req = '0;
        c = 0;
        while (n_load[1] == 0 && c < 10) begin tick(); c++; end
        wait_idle(60, "s4_idle");
        check("s4_done", 64'(n_done[1]), 64'd1);
        check("s4_no_err", 64'(n_err[1]), 64'd0);
        check("s4_wait_len", 64'(first_wait[1]), 64'd16);
        check("s4_z", 64'(z[1]), 64'd9);

        // Reset during WAIT of requester 2, request kept high.
        eng_lat[0] = 30; eng_lat[1] = 30;
        clear_rec();
        req = 4'b0100;
        c = 0;
        while (wait_run[0] < 5 && c < 20) begin tick(); c++; end
        check("s5_in_wait", 64'(busy[0] && !ld[0] && en[0]), 64'd1);
        iReset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++)
            check("s5_reset_now",
                  pack(grant[d], done[d], err[d], busy[d], en[d], ld[d], z[d], mx[d], my[d]), 64'd0);
        tick(); tick();
        clear_rec();
        iReset_n = 1'b1;
        c = 0;
        while (n_load[0] == 0 && c < 10) begin tick(); c++; end
        check("s5_regrant", {order[0][0][3:0], order[1][0][3:0]}, 64'h22);
        req = '0;
        wait_idle(60, "s5_idle");
        check("s5_done", 64'(done_mask[0]), 64'b0100);
        check("s5_z", 64'(z[0]), 64'd9);

        // Requester 3 drops its request during WAIT; then a stray valid in IDLE.
        eng_lat[0] = 10; eng_lat[1] = 10;
        clear_rec();
        req = 4'b1000;
        c = 0;
        while (wait_run[0] < 2 && c < 20) begin tick(); c++; end
        req = '0;
        wait_idle(40, "s6_idle");
        check("s6_done", 64'(done_mask[0]), 64'b1000);
        check("s6_done_count", 64'(n_done[0]), 64'd1);
        z_keep[0] = z[0];
        z_keep[1] = z[1];
        loads_keep = n_load[0];
        stray_z = 8'hA5;
        stray[0] = 1; stray[1] = 1;
        for (int i = 0; i < 4; i++) tick();
        check("s6_stray_idle", 64'(busy[0] | busy[1]), 64'd0);
        check("s6_stray_z", {z[0], z[1]}, {z_keep[0], z_keep[1]});
        check("s6_stray_loads", 64'(n_load[0]), 64'(loads_keep));

        // Randomized traffic against the reference models.
        eng_lat[0] = 0; eng_lat[1] = 0;
        for (int i = 0; i < 600; i++) begin
            req = N'($urandom & $urandom);
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < N; k++) begin
                    x_flat[k*IW +: IW] = IW'($urandom);
                    y_flat[k*IW +: IW] = IW'($urandom_range(1, 65535));
                end
            end
            if ($urandom_range(0, 19) == 0) begin
                stray_z  = OW'($urandom);
                stray[0] = 1;
                stray[1] = 1;
            end
            tick();
        end
        req = '0;
        wait_idle(200, "rand_drain");

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mod_arbiter.md
MOD_ARBITER -- requirements
Module: mod_arbiter

Interface
REQ-001 Parameter N, default 4, is the number of requesters sharing one modular-reduction engine.
REQ-002 Parameter iW, default 2048, is the operand width.
REQ-003 Parameter oW, default 1024, is the result width.
REQ-004 Parameter TIMEOUT, default 1000000, is the maximum number of WAIT cycles per job; the 24-bit counter SHALL hold it.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with ports named iClk and iReset_n as the codebase does.
REQ-006 Ports SHALL be, one per line:
- iClk  in  1  clock.
- iReset_n  in  1  async active-low reset.
- iReq  in  N  per-requester job request, level.
- iX  in  N*iW  flattened dividends; slice k = requester k.
- iY  in  N*iW  flattened moduli; slice k = requester k.
- oGrant  out  N  one-hot owner of the engine, held LOAD..DONE/ERR.
- oDone  out  N  one-cycle completion pulse to the owner.
- oErr  out  N  one-cycle timeout pulse to the owner.
- oZ  out  oW  registered result of the last completed job.
- oBusy  out  1  high in any state other than IDLE.
- oModEnable  out  1  engine enable; low clears the engine.
- oModLoad  out  1  engine load strobe.
- oModX  out  iW  engine dividend.
- oModY  out  iW  engine modulus.
- iModValid  in  1  engine result-valid pulse.
- iModZ  in  oW  engine result.

Function
REQ-007 The FSM SHALL have states IDLE, LOAD, WAIT, DONE and ERR, and SHALL reset to IDLE.
REQ-008 IDLE: oModEnable=0, oModLoad=0.
- Any iReq bit high -> LOAD next cycle.
- The granted index is latched on that edge.
REQ-009 Arbitration SHALL be round-robin: grant the first requesting index after the last granted one, circularly. After reset, last-granted = N-1, so requester 0 has priority first.
REQ-010 LOAD lasts exactly one cycle: oModEnable=1, oModLoad=1, oModX/oModY = slice g of iX/iY; then -> WAIT with the counter cleared.
REQ-011 oModX/oModY SHALL be the granted slices combinationally in all states, and zero when no grant is held.
REQ-012 WAIT: oModEnable=1, oModLoad=0, counter +1 per cycle.
- iModValid=1 -> capture iModZ into oZ and go to DONE.
- Else counter == TIMEOUT-1 -> ERR.
REQ-013 If iModValid and timeout occur in the same cycle, valid SHALL win (DONE, oZ captured).
REQ-014 DONE lasts one cycle: oDone[g]=1, oModEnable=0 (clears the engine); then -> IDLE, last-granted = g, oGrant cleared.
REQ-015 ERR lasts one cycle: oErr[g]=1, oModEnable=0, oZ unchanged; then -> IDLE, last-granted = g.
REQ-016 oModEnable SHALL be low for at least one cycle between any two jobs (IDLE/DONE/ERR), so the engine always starts from its initial state.
REQ-017 iModValid outside WAIT SHALL be ignored.
REQ-018 Deasserting iReq[g] after grant SHALL NOT abort the job; DONE/ERR still pulse.
REQ-019 Requesters SHALL hold iX/iY stable from iReq rise through the LOAD cycle; only the LOAD-cycle value is sampled.
REQ-020 Minimum job time SHALL be 1 cycle LOAD + engine latency + 1 cycle DONE + 1 cycle IDLE before the next LOAD.

Reset
REQ-021 iReset_n low SHALL asynchronously force:
- state IDLE, oGrant=0, oDone=0, oErr=0, oZ=0, oBusy=0;
- oModEnable=0, oModLoad=0;
- counter=0, last-granted = N-1.
REQ-022 Reset asserted mid-job SHALL discard the job with no oDone/oErr pulse. After release the block SHALL restart in IDLE and re-arbitrate the still-pending iReq bits.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Single job: iReq=0001, X=1000, Y=7; engine model returns 6 after 40 cycles -> oGrant=0001 for the whole job, one LOAD pulse, oZ=6, oDone=0001 once, oBusy falls the cycle after DONE.
- Contention: iReq=1111 held -> grant order 0,1,2,3,0. The oModEnable low gap is >=1 cycle between every pair of jobs.
- Timeout: engine never asserts valid, TIMEOUT=16 -> ERR after exactly 16 WAIT cycles, oErr pulse on the owner, oZ unchanged, next requester then granted.
- Valid on the last timeout cycle -> DONE, not ERR, and oZ updated.
- Reset during WAIT of requester 2 -> all outputs 0 immediately, no oDone/oErr. After release with iReq=0100 still high, requester 2 is re-granted via a fresh LOAD.
- Requester drops iReq in WAIT, and a stray iModValid arrives in IDLE -> the job still completes with oDone, and the stray pulse causes no state change.
